// File: rtl/rsa_box_pkg.sv
// rtl/rsa_box_pkg.sv - opcodes, FSM states, register map and per-opcode word counts
package rsa_box_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_CLEAR  = 4'd1,
    OP_LOAD_N = 4'd2,
    OP_LOAD_E = 4'd3,
    OP_LOAD_P = 4'd4,
    OP_LOAD_Q = 4'd5,
    OP_READ_N = 4'd8,
    OP_READ_E = 4'd9
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR,
    ST_DATA,
    ST_READ,
    ST_DRAIN,
    ST_RESP
  } state_e;

  localparam logic [2:0] ADDR_INSTR = 3'd0;
  localparam logic [2:0] ADDR_DATA0 = 3'd1;

  localparam logic [2:0] NDATA_CLEAR  = 3'd1;
  localparam logic [2:0] NDATA_LOAD_N = 3'd4;
  localparam logic [2:0] NDATA_LOAD_E = 3'd1;
  localparam logic [2:0] NDATA_LOAD_P = 3'd2;
  localparam logic [2:0] NDATA_LOAD_Q = 3'd2;
  localparam logic [2:0] NDATA_READ_N = 3'd4;
  localparam logic [2:0] NDATA_READ_E = 3'd1;

  localparam logic [2:0] NREAD_READ_N = 3'd4;
  localparam logic [2:0] NREAD_READ_E = 3'd1;

  // NOP has no bus sequence, so it is reported like any other unknown code.
  function automatic logic op_known(input logic [3:0] op);
    case (op)
      OP_CLEAR, OP_LOAD_N, OP_LOAD_E, OP_LOAD_P,
      OP_LOAD_Q, OP_READ_N, OP_READ_E: op_known = 1'b1;
      default:                         op_known = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] data_words(input logic [3:0] op);
    case (op)
      OP_CLEAR:  data_words = NDATA_CLEAR;
      OP_LOAD_N: data_words = NDATA_LOAD_N;
      OP_LOAD_E: data_words = NDATA_LOAD_E;
      OP_LOAD_P: data_words = NDATA_LOAD_P;
      OP_LOAD_Q: data_words = NDATA_LOAD_Q;
      OP_READ_N: data_words = NDATA_READ_N;
      OP_READ_E: data_words = NDATA_READ_E;
      default:   data_words = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] read_words(input logic [3:0] op);
    case (op)
      OP_READ_N: read_words = NREAD_READ_N;
      OP_READ_E: read_words = NREAD_READ_E;
      default:   read_words = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/rsa_box_host_driver_if.sv
// rtl/rsa_box_host_driver_if.sv - command/response stream plus Avalon-MM master bus
interface rsa_box_host_driver_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int KEY_W  = 128
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [KEY_W-1:0]  cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [KEY_W-1:0]  rsp_data;
  logic              rsp_err;
  logic              e_valid;
  logic              av_chipselect;
  logic              av_write;
  logic [ADDR_W-1:0] av_address;
  logic [DATA_W-1:0] av_writedata;
  logic [DATA_W-1:0] av_readdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, av_readdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, e_valid,
           av_chipselect, av_write, av_address, av_writedata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, av_readdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, e_valid,
           av_chipselect, av_write, av_address, av_writedata
  );
endinterface

// File: rtl/rsa_box_rd_capture.sv
// rtl/rsa_box_rd_capture.sv - read-latency delay line steering readdata into the response word
module rsa_box_rd_capture #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int KEY_W  = 128,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [KEY_W-1:0]  rsp_data
);
  localparam int NWORDS = KEY_W / DATA_W;

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [ADDR_W-1:0] addr_d [RD_LAT];
  logic [KEY_W-1:0]  data_q, data_d;

  always_comb begin
    vld_d[0]  = rd_req;
    addr_d[0] = rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
    data_d = data_q;
    // The last stage lines up with the cycle the slave presents readdata.
    if (clr) begin
      data_d = '0;
    end else if (vld_q[RD_LAT-1]) begin
      for (int k = 0; k < NWORDS; k++) begin
        if (addr_q[RD_LAT-1] == ADDR_W'(k)) data_d[k*DATA_W +: DATA_W] = rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      data_q <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      for (int i = 0; i < RD_LAT; i++) addr_q[i] <= addr_d[i];
    end
  end

  assign rsp_data = data_q;
endmodule

// File: rtl/rsa_box_host_driver.sv
// rtl/rsa_box_host_driver.sv - expands one key command into the RSA box register access sequence
module rsa_box_host_driver
  import rsa_box_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int KEY_W  = 128,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  rsa_box_host_driver_if.master bus
);
  localparam int NWORDS = KEY_W / DATA_W;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [KEY_W-1:0]  data_q, data_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              e_valid_q, e_valid_d;
  logic              av_cs_q, av_cs_d;
  logic              av_wr_q, av_wr_d;
  logic [ADDR_W-1:0] av_addr_q, av_addr_d;
  logic [DATA_W-1:0] av_wdata_q, av_wdata_d;
  logic              cap_clr;

  logic [DATA_W-1:0] words [NWORDS];
  logic [2:0]        nxt_idx;
  logic [DATA_W-1:0] nxt_word;
  logic [ADDR_W-1:0] nxt_addr;

  always_comb begin
    for (int i = 0; i < NWORDS; i++) words[i] = data_q[i*DATA_W +: DATA_W];
  end

  // Next data/read word: read commands write zeros, and CLEAR's second write
  // goes back to the instruction register so instruction 1 never stays resident.
  always_comb begin
    nxt_idx  = (state_q == ST_INSTR) ? 3'd0 : cnt_q + 3'd1;
    nxt_word = (op_q == OP_CLEAR || read_words(op_q) != 3'd0) ? '0 : words[nxt_idx[1:0]];
    nxt_addr = (op_q == OP_CLEAR) ? ADDR_W'(ADDR_INSTR) : ADDR_W'(nxt_idx) + ADDR_W'(ADDR_DATA0);
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    e_valid_d   = e_valid_q;
    av_cs_d     = 1'b0;
    av_wr_d     = 1'b0;
    av_addr_d   = '0;
    av_wdata_d  = '0;
    cap_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d        = bus.cmd_op;
          data_d      = bus.cmd_data;
          cmd_ready_d = 1'b0;
          cap_clr     = 1'b1;
          state_d     = ST_INSTR;
          if (op_known(bus.cmd_op)) begin
            av_cs_d    = 1'b1;
            av_wr_d    = 1'b1;
            av_addr_d  = ADDR_W'(ADDR_INSTR);
            av_wdata_d = DATA_W'(bus.cmd_op);
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end

      ST_INSTR: begin
        if (!op_known(op_q)) begin
          // Error response is already visible this cycle and may be taken at once.
          if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          cnt_d      = 3'd0;
          state_d    = ST_DATA;
          av_cs_d    = 1'b1;
          av_wr_d    = 1'b1;
          av_addr_d  = nxt_addr;
          av_wdata_d = nxt_word;
        end
      end

      ST_DATA: begin
        if (cnt_q == data_words(op_q) - 3'd1) begin
          if (read_words(op_q) != 3'd0) begin
            cnt_d     = 3'd0;
            state_d   = ST_READ;
            av_cs_d   = 1'b1;
            av_addr_d = '0;
          end else begin
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
            if (op_q == OP_LOAD_E) e_valid_d = 1'b1;
          end
        end else begin
          cnt_d      = cnt_q + 3'd1;
          av_cs_d    = 1'b1;
          av_wr_d    = 1'b1;
          av_addr_d  = nxt_addr;
          av_wdata_d = nxt_word;
        end
      end

      ST_READ: begin
        if (cnt_q == read_words(op_q) - 3'd1) begin
          cnt_d   = 3'd0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d     = cnt_q + 3'd1;
          av_cs_d   = 1'b1;
          av_addr_d = ADDR_W'(nxt_idx);
        end
      end

      ST_DRAIN: begin
        if (cnt_q == 3'(RD_LAT - 1)) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // While the slave holds instruction 3 any write lands in e, so the first
    // instruction write of any later command invalidates it.
    if (av_cs_d && av_wr_d && av_addr_d == ADDR_W'(ADDR_INSTR)) e_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      e_valid_q   <= 1'b0;
      av_cs_q     <= 1'b0;
      av_wr_q     <= 1'b0;
      av_addr_q   <= '0;
      av_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      e_valid_q   <= e_valid_d;
      av_cs_q     <= av_cs_d;
      av_wr_q     <= av_wr_d;
      av_addr_q   <= av_addr_d;
      av_wdata_q  <= av_wdata_d;
    end
  end

  rsa_box_rd_capture #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .KEY_W  (KEY_W),
    .RD_LAT (RD_LAT)
  ) u_rd_capture (
    .clk      (clk),
    .reset    (reset),
    .clr      (cap_clr),
    .rd_req   (av_cs_q && !av_wr_q),
    .rd_addr  (av_addr_q),
    .rd_data  (bus.av_readdata),
    .rsp_data (bus.rsp_data)
  );

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.e_valid       = e_valid_q;
  assign bus.av_chipselect = av_cs_q;
  assign bus.av_write      = av_wr_q;
  assign bus.av_address    = av_addr_q;
  assign bus.av_writedata  = av_wdata_q;
endmodule
